// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: MD tracker state
// encodings and branch-resolve stage identifiers.
package hazard_ctrl_unit_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam int BR_ID = 2;
  localparam int BR_EX = 3;

  localparam int N_PERF_CNT = 2;
  localparam int PERF_STALL = 0;
  localparam int PERF_FLUSH = 1;

endpackage

// File: rtl/hazard_ctrl_unit_md_busy_tracker.sv
// Tracks occupancy of the multi-cycle MUL/DIV unit and flags an md_start
// that arrives while an operation is still in flight.
module md_busy_tracker
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  output logic md_busy,
  output logic md_err
);

  localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  md_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= MD_IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      MD_IDLE: begin
        if (md_start) begin
          state_next = MD_BUSY;
          cnt_next   = CW'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        // A second issue while busy is an error; the running op keeps its schedule.
        if (md_start) begin
          err_next = 1'b1;
        end
        if (cnt_reg == CW'(1)) begin
          state_next = MD_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: begin
        state_next = MD_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign md_busy = (state_reg == MD_BUSY);
  assign md_err  = err_reg;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Unified hazard controller for the 5-stage pipeline: redirect flushes,
// load-use and MUL/DIV busy stalls, plus saturating stall/flush counters.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int BR_STAGE = 2,
  parameter int REG_AW   = 5,
  parameter int MD_LAT   = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_use_hilo,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              md_start,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              md_busy,
  output logic              md_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic lu, mdh, rd;

  md_busy_tracker #(
    .MD_LAT(MD_LAT)
  ) u_md_busy_tracker (
    .clk     (clk),
    .rst     (rst),
    .md_start(md_start),
    .md_busy (md_busy),
    .md_err  (md_err)
  );

  // Register $0 is hardwired zero, so a load targeting it never creates a hazard.
  assign lu  = ex_memread && (ex_rt != '0) &&
               ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
  assign mdh = md_busy && id_use_hilo;
  assign rd  = jump || branch_taken;

  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst) begin
      if (rd) begin
        // The stalled instruction is on the wrong path anyway, so redirect wins.
        ifid_flush = 1'b1;
        idex_flush = (BR_STAGE == BR_EX) && branch_taken;
      end else if (lu || mdh) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  logic [N_PERF_CNT-1:0]            cnt_en;
  logic [N_PERF_CNT-1:0][CNT_W-1:0] cnt_val;

  assign cnt_en[PERF_STALL] = pc_stall;
  assign cnt_en[PERF_FLUSH] = ifid_flush;

  genvar gi;
  generate
    for (gi = 0; gi < N_PERF_CNT; gi++) begin : g_perf
      logic [CNT_W-1:0] cnt_reg, cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (cnt_en[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign stall_cnt = cnt_val[PERF_STALL];
  assign flush_cnt = cnt_val[PERF_FLUSH];

endmodule
